// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_arb_pkg
//  Description : Shared encodings and constants for the program/data RAM
//                arbiter and its read-return pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
package ram_arb_pkg;

    // Arbiter FSM states
    typedef enum logic [0:0] {
        SHARE  = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Owner of a RAM access
    typedef enum logic [0:0] {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_t;

    // Legal range of the RAM read latency
    localparam int c_RD_LAT_MIN = 1;
    localparam int c_RD_LAT_MAX = 3;

    // Forces an out-of-range latency parameter back into the supported range
    function automatic int clamp_rd_lat(input int lat);
        if (lat < c_RD_LAT_MIN) begin
            return c_RD_LAT_MIN;
        end else if (lat > c_RD_LAT_MAX) begin
            return c_RD_LAT_MAX;
        end
        return lat;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rd_return_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : rd_return_pipe
//  Description : RD_LAT-deep {valid, owner} shift register that tracks granted
//                reads until the RAM data appears, then raises the owning
//                requester's rvalid.
//  Revision    : 1.0 - initial release
// ============================================================================
module rd_return_pipe
    import ram_arb_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   push_valid,
    input  owner_t push_owner,
    output logic   cpu_rvalid,
    output logic   dbg_rvalid
);

    localparam int c_DEPTH = clamp_rd_lat(RD_LAT);

    logic [c_DEPTH-1:0] r_valid;
    logic [c_DEPTH-1:0] r_owner;
    logic               w_out_valid;
    logic               w_out_dbg;

    if (c_DEPTH == 1) begin : g_single
        // Single stage: the entry pushed this cycle is presented next cycle
        always_ff @(posedge clock) begin
            if (reset) begin
                r_valid <= '0;
                r_owner <= '0;
            end else begin
                r_valid <= push_valid;
                r_owner <= push_owner;
            end
        end
    end else begin : g_multi
        // Multi stage: shift toward the output end once per cycle
        always_ff @(posedge clock) begin
            if (reset) begin
                r_valid <= '0;
                r_owner <= '0;
            end else begin
                r_valid <= {r_valid[c_DEPTH-2:0], push_valid};
                r_owner <= {r_owner[c_DEPTH-2:0], push_owner};
            end
        end
    end

    // Reset also masks the output so an entry sitting at the end of the pipe
    // in the first reset cycle never surfaces
    assign w_out_valid = r_valid[c_DEPTH-1] & ~reset;
    assign w_out_dbg   = r_owner[c_DEPTH-1];
    assign cpu_rvalid  = w_out_valid & ~w_out_dbg;
    assign dbg_rvalid  = w_out_valid &  w_out_dbg;

endmodule
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ram_arbiter
//  Description : Shares the single-port program/data RAM between the core and
//                the debug/loader port: one access per cycle, round-robin in
//                normal operation, exclusive debug ownership while locked.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AW     = 16,
    parameter int DW     = 16,
    parameter int RD_LAT = 1
) (
    input  logic          clock,
    input  logic          reset,
    // core port
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    // debug/loader port
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rdata,
    input  logic          dbg_lock,
    // RAM side
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_data,
    output logic          mem_wren,
    input  logic [DW-1:0] mem_q
);

    arb_state_t r_state;
    owner_t     r_last_winner;
    logic       r_cpu_stall;

    logic       w_cpu_gnt;
    logic       w_dbg_gnt;
    logic       w_rd_push;
    owner_t     w_rd_owner;

    // Winner selection from requests, FSM state and the previous winner
    always_comb begin
        w_cpu_gnt = 1'b0;
        w_dbg_gnt = 1'b0;
        if (!reset) begin
            if (r_state == LOCKED) begin
                w_dbg_gnt = dbg_req;
            end else if (cpu_req && dbg_req) begin
                w_cpu_gnt = (r_last_winner == OWN_DBG);
                w_dbg_gnt = (r_last_winner == OWN_CPU);
            end else begin
                w_cpu_gnt = cpu_req;
                w_dbg_gnt = dbg_req;
            end
        end
    end

    assign cpu_gnt = w_cpu_gnt;
    assign dbg_gnt = w_dbg_gnt;

    // The core fields sit on the RAM bus whenever debug is not the winner,
    // which keeps the bus stable in idle cycles
    assign mem_address = w_dbg_gnt ? dbg_addr  : cpu_addr;
    assign mem_data    = w_dbg_gnt ? dbg_wdata : cpu_wdata;
    assign mem_wren    = (w_cpu_gnt & cpu_we) | (w_dbg_gnt & dbg_we);

    assign w_rd_push  = (w_cpu_gnt & ~cpu_we) | (w_dbg_gnt & ~dbg_we);
    assign w_rd_owner = w_dbg_gnt ? OWN_DBG : OWN_CPU;

    // Share/lock FSM with round-robin history and registered stall output
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= SHARE;
            r_last_winner <= OWN_DBG;
            r_cpu_stall   <= 1'b0;
        end else begin
            r_cpu_stall <= dbg_lock;
            if (r_state == SHARE) begin
                if (w_cpu_gnt) begin
                    r_last_winner <= OWN_CPU;
                end else if (w_dbg_gnt) begin
                    r_last_winner <= OWN_DBG;
                end
                if (dbg_lock) begin
                    r_state <= LOCKED;
                end
            end else begin
                // Debug owned the RAM, so the core gets the first turn after
                // unlock
                if (!dbg_lock) begin
                    r_state       <= SHARE;
                    r_last_winner <= OWN_DBG;
                end else if (w_dbg_gnt) begin
                    r_last_winner <= OWN_DBG;
                end
            end
        end
    end

    assign cpu_stall = r_cpu_stall;

    // RAM data goes to both ports; only rvalid says whose it is
    assign cpu_rdata = mem_q;
    assign dbg_rdata = mem_q;

    rd_return_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_return_pipe (
        .clock      (clock),
        .reset      (reset),
        .push_valid (w_rd_push),
        .push_owner (w_rd_owner),
        .cpu_rvalid (cpu_rvalid),
        .dbg_rvalid (dbg_rvalid)
    );

endmodule
`default_nettype wire

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port program/data RAM between two requesters:
  - the processor core (instruction fetch, LD/ST);
  - a debug/loader port (program download over switches, memory inspection on the 7-seg display).
- Arbitrates one access per cycle between them.
- Drives the RAM address, data and write-enable.
- Returns read data to the owning requester after the fixed RAM read latency.
- Lets the debug port lock the RAM, stalling the core for the whole lock.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- RD_LAT, 1, RAM read latency in cycles from address presentation to valid q (legal 1..3).

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  core access request; core holds it and its fields until cpu_gnt=1
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  AW  core address
- cpu_wdata  in  DW  core write data
- cpu_gnt  out  1  access accepted this cycle (combinational)
- cpu_rvalid  out  1  cpu_rdata valid this cycle
- cpu_rdata  out  DW  read data
- cpu_stall  out  1  registered; 1 while RAM is locked by debug
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata  same meanings for the debug port
- dbg_lock  in  1  debug requests exclusive ownership
- mem_address  out  AW  to RAM address
- mem_data  out  DW  to RAM write data
- mem_wren  out  1  RAM write enable
- mem_q  in  DW  RAM read data

Behaviour:
- Handshake:
  - A transfer occurs in the cycle where req=1 and gnt=1.
  - gnt is never 1 when req=0.
  - At most one of cpu_gnt/dbg_gnt is 1 per cycle.
- Winner selection is combinational from req, state and last_winner. The winner's addr/wdata/we drive mem_address/mem_data in the same cycle.
- mem_wren = winner_we & gnt. mem_wren must be 0 in any cycle with no grant.
- With no grant, mem_address = cpu_addr and mem_data = cpu_wdata (don't-care, but stable).
- FSM, 2 states:
  - SHARE:
    - Round-robin. If both requesters are active, grant the one that is not last_winner.
    - If only one is active, grant it.
    - last_winner updates on every grant.
  - LOCKED:
    - Only debug is granted. cpu_gnt=0.
    - Core requests wait with no loss.
  - SHARE->LOCKED when dbg_lock=1 at a clock edge. This happens regardless of dbg_req. The state takes effect the next cycle. A cpu grant in the edge cycle completes normally.
  - LOCKED->SHARE when dbg_lock=0 at a clock edge. last_winner is set to debug, so the core wins first after unlock.
  - cpu_stall = (state==LOCKED), registered.
- Read return:
  - Each granted read pushes {valid=1, owner} into an RD_LAT-deep shift register. Non-read cycles push valid=0.
  - At the output end, owner's rvalid=1 and rdata=mem_q.
  - Both rdata outputs carry mem_q continuously; only rvalid qualifies them.
  - Back-to-back reads from alternating owners return in grant order, one per cycle.
- Writes: one-cycle, no response. A read to the same address granted in the next cycle returns the new data.
- Reset (reset=1 at an edge):
  - state=SHARE, last_winner=debug, return pipeline cleared, cpu_stall=0.
  - While reset=1: cpu_gnt=dbg_gnt=0, mem_wren=0, rvalid=0.
  - Reads in flight when reset is asserted are discarded; no rvalid is ever produced for them.
- Simultaneous events:
  - dbg_lock rising while both request in SHARE: that cycle arbitrates round-robin normally.
  - dbg_lock falling while the core has been waiting: the core is granted in the first SHARE cycle.

Decomposition:
- Shared package ram_arb_pkg holds:
  - state encoding: SHARE=1'b0, LOCKED=1'b1;
  - owner encoding: OWN_CPU=1'b0, OWN_DBG=1'b1;
  - RD_LAT legal range constants.
- One sub-module, rd_return_pipe: RD_LAT-deep {valid, owner} shift register with synchronous clear. Its outputs are cpu_rvalid/dbg_rvalid.

Test Plan:
- Reset and idle: hold reset 3 cycles with both req=1 -> gnts=0, mem_wren=0, rvalids=0. Release reset with both requesting -> cycle 1 cpu_gnt, cycle 2 dbg_gnt, alternating.
- Write then read: cpu writes 0xBEEF to 0x0010, then reads 0x0010 next cycle -> mem_wren=1 only in the write cycle; cpu_rvalid=1 with cpu_rdata=0xBEEF exactly RD_LAT cycles after the read grant; dbg_rvalid stays 0.
- Interleaved reads: both read continuously, addresses 0x0000 (cpu) and 0x0100 (dbg), RAM preloaded addr=data -> rvalids alternate each cycle starting with cpu; data 0x0000, 0x0100, 0x0001, 0x0101, ...
- Lock: assert dbg_lock for 10 cycles while cpu_req=1 -> cpu_stall=1 from the next cycle; no cpu_gnt during LOCKED; first grant after dbg_lock falls goes to cpu.
- Reset mid-read with RD_LAT=3: grant a dbg read, assert reset 1 cycle later -> no dbg_rvalid ever appears; next dbg read returns normally.
- Single requester: dbg_req=1 alone for 5 cycles -> dbg_gnt=1 every cycle, no bubbles.
